ysyx_22050854_mul_gather: RTL

- Back end of the Booth/Wallace multiplier datapath.
- Receives per-column compressor outputs (one sum bit and one carry bit per column) in beats of COLS_PER_BEAT columns.
- Re-assembles the column bits into a 64-bit sum row and a 64-bit carry row, i.e. the column-to-row direction.
- Performs the final carry-propagate add in two 32-bit halves and returns the 64-bit product over a valid/ready handshake.

---
 rtl/ysyx_22050854_mul_pkg.sv | 28 ++
 rtl/ysyx_22050854_add32c.sv | 20 ++
 rtl/ysyx_22050854_mul_gather.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_mul_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_mul_pkg
// Shared definitions for the Booth/Wallace multiplier datapath:
//   - WIDTH          : product width / number of compressor columns
//   - HALF           : width of each half of the split final adder
//   - mul_state_e    : gather-stage FSM encoding (COLLECT/ADD_LO/ADD_HI/DONE)
//   - cpb_is_legal() : the column counts per beat the datapath supports,
//                      shared with the Wallace column stage and the
//                      partial-product transpose
// ---------------------------------------------------------------------------
package ysyx_22050854_mul_pkg;

  localparam int WIDTH = 64;
  localparam int HALF  = WIDTH / 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ADD_LO  = 2'd1,
    ADD_HI  = 2'd2,
    DONE    = 2'd3
  } mul_state_e;

  // Columns per beat must divide WIDTH into a power-of-two beat count.
  function automatic bit cpb_is_legal(input int cpb);
    return (cpb == 8) || (cpb == 16) || (cpb == 32) || (cpb == 64);
  endfunction

endpackage

// File: rtl/ysyx_22050854_add32c.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_add32c
// 32-bit ripple/carry-propagate adder with carry-in and carry-out. The gather
// stage time-shares one instance across the low and high product halves.
//   a_i, b_i : 32-bit operands
//   cin_i    : carry in
//   sum_o    : 32-bit sum
//   cout_o   : carry out
// ---------------------------------------------------------------------------
module ysyx_22050854_add32c (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/ysyx_22050854_mul_gather.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_mul_gather
// Back end of the Booth/Wallace multiplier. Collects per-column sum/carry bits
// in beats of COLS_PER_BEAT columns (column order, lowest beat first), builds
// the 64-bit sum and carry rows, does the final carry-propagate add and hands
// the product out over valid/ready.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : abandon the product in flight
//   in_valid/in_ready   : beat handshake
//   in_col_s, in_col_c  : sum / carry-out bit per column of the current beat
//   out_valid/out_ready : product handshake
//   out_result          : final product (held while out_valid && !out_ready)
//
// Build option:
//   YSYX_22050854_MUL_GATHER_FASTADD_EN - single-cycle 64-bit final add,
//   removes ADD_HI and the lo_carry register. Default is a 32+32 split add.
// ---------------------------------------------------------------------------
module ysyx_22050854_mul_gather
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int COLS_PER_BEAT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COLS_PER_BEAT-1:0] in_col_s,
  input  logic [COLS_PER_BEAT-1:0] in_col_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result
);

  localparam int NBEATS = WIDTH / COLS_PER_BEAT;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

  if (!cpb_is_legal(COLS_PER_BEAT)) begin : g_illegal_cpb
    $error("COLS_PER_BEAT must be 8, 16, 32 or 64");
  end

  mul_state_e       state_q;
  logic [BCW-1:0]   beat_cnt_q;
  logic [WIDTH-1:0] sum_row_q;
  logic [WIDTH-1:0] colc_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;

  // Column i's carry-out feeds column i+1; the carry out of the top column
  // falls off the end because the product is taken mod 2^WIDTH.
  logic [WIDTH-1:0] carry_row;
  logic             colc_unused;
  assign carry_row   = {colc_q[WIDTH-2:0], 1'b0};
  assign colc_unused = colc_q[WIDTH-1];

`ifndef YSYX_22050854_MUL_GATHER_FASTADD_EN
  logic            lo_carry_q;
  logic [HALF-1:0] add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  // One adder serves both halves: low half in ADD_LO, high half plus the
  // saved low-half carry in ADD_HI.
  assign add_a   = (state_q == ADD_LO) ? sum_row_q[HALF-1:0] : sum_row_q[WIDTH-1:HALF];
  assign add_b   = (state_q == ADD_LO) ? carry_row[HALF-1:0] : carry_row[WIDTH-1:HALF];
  assign add_cin = (state_q == ADD_LO) ? 1'b0 : lo_carry_q;

  ysyx_22050854_add32c u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );
`endif

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      beat_cnt_q   <= '0;
      sum_row_q    <= '0;
      colc_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifndef YSYX_22050854_MUL_GATHER_FASTADD_EN
      lo_carry_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Kill beats in flight; out_result is left as-is.
      state_q     <= COLLECT;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            for (int b = 0; b < NBEATS; b++) begin
              if (beat_cnt_q == BCW'(b)) begin
                sum_row_q[b*COLS_PER_BEAT +: COLS_PER_BEAT] <= in_col_s;
                colc_q[b*COLS_PER_BEAT +: COLS_PER_BEAT]    <= in_col_c;
              end
            end
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= '0;
              state_q    <= ADD_LO;
            end else begin
              beat_cnt_q <= beat_cnt_q + BCW'(1);
            end
          end
        end

`ifdef YSYX_22050854_MUL_GATHER_FASTADD_EN
        ADD_LO: begin
          out_result_q <= sum_row_q + carry_row;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
`else
        ADD_LO: begin
          {lo_carry_q, out_result_q[HALF-1:0]} <= {add_cout, add_sum};
          state_q <= ADD_HI;
        end

        ADD_HI: begin
          out_result_q[WIDTH-1:HALF] <= add_sum;
          out_valid_q                <= 1'b1;
          state_q                    <= DONE;
        end
`endif

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= COLLECT;
          end
        end

        default: begin
          state_q    <= COLLECT;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  // in_ready decodes the registered state only, so it carries no input path.
  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule
